// File: rtl/dcpu16_abus_resp.sv
// dcpu16_abus_resp: wait-stated single-port memory target for the DCPU16 AB bus.
// Optional write protection below ROM_TOP via `DCPU16_ABUS_RESP_WPROT_EN.
module dcpu16_abus_resp #(
  parameter int          AW      = 16,
  parameter int          WAIT    = 0,
  parameter logic [15:0] ROM_TOP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ab_adr,
  input  logic        ab_stb,
  input  logic        ab_wre,
  input  logic [15:0] ab_dto,
  output logic [15:0] ab_dti,
  output logic        ab_ack
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] adr_q, dto_q, dti_q, dti_d;
  logic        wre_q;
  logic [15:0] mem_q [2**AW];
  logic        acc, go, a_wre, wr_ok;
  logic [15:0] a_adr, a_dto;
  assign acc = ab_stb && state_q != S_WAIT;
  assign go = rst && (WAIT == 0 ? acc : state_q == S_WAIT && cnt_q == 4'd0);
  // with no wait states the access happens on the accepting edge, so use live inputs
  assign a_adr = WAIT == 0 ? ab_adr : adr_q;
  assign a_wre = WAIT == 0 ? ab_wre : wre_q;
  assign a_dto = WAIT == 0 ? ab_dto : dto_q;
`ifdef DCPU16_ABUS_RESP_WPROT_EN
  assign wr_ok = a_adr >= ROM_TOP;
`else
  assign wr_ok = (ROM_TOP & 16'h0000) == 16'h0000;
`endif
  always_comb begin
    state_d = acc ? (WAIT == 0 ? S_ACK : S_WAIT)
            : state_q == S_WAIT ? (cnt_q == 4'd0 ? S_ACK : S_WAIT) : S_IDLE;
    cnt_d = acc ? (WAIT == 0 ? 4'd0 : 4'(WAIT - 1))
          : state_q == S_WAIT && cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0;
    dti_d = go && !a_wre ? mem_q[a_adr[AW-1:0]] : dti_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      dti_q <= '0;
      adr_q <= '0;
      wre_q <= 1'b0;
      dto_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dti_q <= dti_d;
      if (acc) begin
        adr_q <= ab_adr;
        wre_q <= ab_wre;
        dto_q <= ab_dto;
      end
    end
  always_ff @(posedge clk)
    if (go && a_wre && wr_ok) mem_q[a_adr[AW-1:0]] <= a_dto;
  assign ab_ack = state_q == S_ACK;
  assign ab_dti = dti_q;
endmodule
